// File: rtl/irig_b_frame_decoder.sv
// IRIG-B frame decoder: aligns on the P0/Pr double marker, captures the BCD time fields
// and publishes sec, min, hour, day, year with one-cycle strobes after each field's closing marker.
module irig_b_frame_decoder #(
    parameter int SYM_TIMEOUT = 1875000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Sym_vld,
    input  logic [1:0] Sym_type,
    output logic [6:0] RxSecond,
    output logic [6:0] RxMinute,
    output logic [5:0] RxHour,
    output logic [9:0] RxDayOfYear,
    output logic [7:0] RxYear,
    output logic       Rx_sec_vld,
    output logic       Rx_min_vld,
    output logic       Rx_hour_vld,
    output logic       Rx_day_vld,
    output logic       Rx_year_vld,
    output logic       Locked,
    output logic       Frame_err
);
    localparam int CNT_W = $clog2(SYM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYM_TIMEOUT);
    localparam logic [1:0] SYM_P   = 2'd2;
    localparam logic [1:0] SYM_INV = 2'd3;
    localparam int NUM_DIGITS = 11;
    // Digit order: sec u/t, min u/t, hour u/t, day u/t/h, year u/t.
    localparam int DIGIT_START [NUM_DIGITS] = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
    localparam int DIGIT_WIDTH [NUM_DIGITS] = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4};

    typedef enum logic [1:0] {
        HUNT,
        MARK1,
        FRAME
    } state_t;

    state_t                       state_reg, state_next;
    logic [6:0]                   index_reg, index_next;
    logic [6:0]                   idx_in;
    logic                         is_marker;
    logic                         capture;
    logic [CNT_W-1:0]             tmo_cnt_reg;
    logic                         timeout;
    logic [NUM_DIGITS-1:0][3:0]   digit_reg;
    logic [NUM_DIGITS-1:0]        digit_ok;
    logic                         sec_ok, min_ok, hour_ok, day_ok, year_ok;
    logic                         field_ok;
    logic                         locked_next, err_next;
    logic [4:0]                   pub_next;

    assign idx_in = (index_reg == 7'd99) ? 7'd0 : index_reg + 7'd1;

    assign is_marker = (idx_in == 7'd0)  || (idx_in == 7'd9)  || (idx_in == 7'd19) ||
                       (idx_in == 7'd29) || (idx_in == 7'd39) || (idx_in == 7'd49) ||
                       (idx_in == 7'd59) || (idx_in == 7'd69) || (idx_in == 7'd79) ||
                       (idx_in == 7'd89) || (idx_in == 7'd99);

    assign capture = Sym_vld && (state_reg == FRAME) && !Sym_type[1];

    // Bits arrive LSB first; each digit bit is written at its fixed frame position.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            digit_reg <= '0;
        end else if (capture) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                for (int b = 0; b < 4; b++) begin
                    if (b < DIGIT_WIDTH[d] && int'(idx_in) == DIGIT_START[d] + b) begin
                        digit_reg[d][b] <= Sym_type[0];
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_ok
            assign digit_ok[gi] = (digit_reg[gi] <= 4'd9);
        end
    endgenerate

    assign sec_ok  = digit_ok[0] && digit_ok[1] && (digit_reg[1] <= 4'd5);
    assign min_ok  = digit_ok[2] && digit_ok[3] && (digit_reg[3] <= 4'd5);
    assign hour_ok = digit_ok[4] && digit_ok[5] &&
                     ((digit_reg[5] < 4'd2) || (digit_reg[5] == 4'd2 && digit_reg[4] <= 4'd3));
    // Day 000 is illegal; 3xx is only legal up to 366.
    assign day_ok  = digit_ok[6] && digit_ok[7] && digit_ok[8] &&
                     !(digit_reg[8] == 4'd0 && digit_reg[7] == 4'd0 && digit_reg[6] == 4'd0) &&
                     !(digit_reg[8] == 4'd3 && ((digit_reg[7] > 4'd6) ||
                                                (digit_reg[7] == 4'd6 && digit_reg[6] > 4'd6)));
    assign year_ok = digit_ok[9] && digit_ok[10];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tmo_cnt_reg <= '0;
        end else if (Sym_vld) begin
            tmo_cnt_reg <= '0;
        end else if (tmo_cnt_reg != CNT_MAX) begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
        end
    end

    // Fires on the edge where the counter reaches SYM_TIMEOUT.
    assign timeout = !Sym_vld && (state_reg != HUNT) && (tmo_cnt_reg == CNT_MAX - CNT_W'(1));

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        locked_next = Locked;
        err_next    = 1'b0;
        pub_next    = '0;
        field_ok    = 1'b1;
        if (Sym_vld) begin
            case (state_reg)
                HUNT: begin
                    if (Sym_type == SYM_P) state_next = MARK1;
                end
                MARK1: begin
                    if (Sym_type == SYM_P) begin
                        index_next = '0;
                        state_next = FRAME;
                    end else begin
                        state_next = HUNT;
                    end
                end
                FRAME: begin
                    index_next = idx_in;
                    if (Sym_type == SYM_INV || (is_marker && Sym_type != SYM_P)) begin
                        err_next    = 1'b1;
                        locked_next = 1'b0;
                        state_next  = HUNT;
                    end else if (!is_marker && Sym_type == SYM_P) begin
                        // A stray P may itself be the P0 of a new reference.
                        err_next    = 1'b1;
                        locked_next = 1'b0;
                        state_next  = MARK1;
                    end else if (is_marker) begin
                        case (idx_in)
                            7'd9:  begin field_ok = sec_ok;  pub_next[0] = sec_ok;  end
                            7'd19: begin field_ok = min_ok;  pub_next[1] = min_ok;  end
                            7'd29: begin field_ok = hour_ok; pub_next[2] = hour_ok; end
                            7'd49: begin field_ok = day_ok;  pub_next[3] = day_ok;  end
                            7'd59: begin field_ok = year_ok; pub_next[4] = year_ok; end
                            7'd99: locked_next = 1'b1;
                            default: ;
                        endcase
                        if (!field_ok) begin
                            err_next    = 1'b1;
                            locked_next = 1'b0;
                            state_next  = HUNT;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end else if (timeout) begin
            err_next    = 1'b1;
            locked_next = 1'b0;
            state_next  = HUNT;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg   <= HUNT;
            index_reg   <= '0;
            Locked      <= 1'b0;
            Frame_err   <= 1'b0;
            Rx_sec_vld  <= 1'b0;
            Rx_min_vld  <= 1'b0;
            Rx_hour_vld <= 1'b0;
            Rx_day_vld  <= 1'b0;
            Rx_year_vld <= 1'b0;
            RxSecond    <= '0;
            RxMinute    <= '0;
            RxHour      <= '0;
            RxDayOfYear <= '0;
            RxYear      <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            Locked      <= locked_next;
            Frame_err   <= err_next;
            Rx_sec_vld  <= pub_next[0];
            Rx_min_vld  <= pub_next[1];
            Rx_hour_vld <= pub_next[2];
            Rx_day_vld  <= pub_next[3];
            Rx_year_vld <= pub_next[4];
            if (pub_next[0]) RxSecond    <= {digit_reg[1][2:0], digit_reg[0]};
            if (pub_next[1]) RxMinute    <= {digit_reg[3][2:0], digit_reg[2]};
            if (pub_next[2]) RxHour      <= {digit_reg[5][1:0], digit_reg[4]};
            if (pub_next[3]) RxDayOfYear <= {digit_reg[8][1:0], digit_reg[7], digit_reg[6]};
            if (pub_next[4]) RxYear      <= {digit_reg[10], digit_reg[9]};
        end
    end

endmodule

// File: tb/tb_irig_b_frame_decoder.sv
// Randomized bench for irig_b_frame_decoder: symbol streams are built from decimal time values
// and compared symbol-by-symbol against a position-based reference model of the frame format.
module tb_irig_b_frame_decoder;
    localparam int TMO = 100;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Sym_vld;
    logic [1:0] Sym_type;
    logic [6:0] RxSecond, RxMinute;
    logic [5:0] RxHour;
    logic [9:0] RxDayOfYear;
    logic [7:0] RxYear;
    logic       Rx_sec_vld, Rx_min_vld, Rx_hour_vld, Rx_day_vld, Rx_year_vld;
    logic       Locked, Frame_err;

    irig_b_frame_decoder #(.SYM_TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Sym_vld(Sym_vld), .Sym_type(Sym_type),
        .RxSecond(RxSecond), .RxMinute(RxMinute), .RxHour(RxHour),
        .RxDayOfYear(RxDayOfYear), .RxYear(RxYear),
        .Rx_sec_vld(Rx_sec_vld), .Rx_min_vld(Rx_min_vld), .Rx_hour_vld(Rx_hour_vld),
        .Rx_day_vld(Rx_day_vld), .Rx_year_vld(Rx_year_vld),
        .Locked(Locked), .Frame_err(Frame_err)
    );

    always #4 Clk = ~Clk;

    logic [4:0]  strobes;
    logic [37:0] fields;
    assign strobes = {Rx_year_vld, Rx_day_vld, Rx_hour_vld, Rx_min_vld, Rx_sec_vld};
    assign fields  = {RxSecond, RxMinute, RxHour, RxDayOfYear, RxYear};

    int n_checks = 0;
    int n_pass   = 0;
    int nsym     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Reference model: mpos = -1 hunting, -2 after one P, 0..99 aligned frame position.
    int         mpos;
    int         rbits [100];
    logic [6:0] e_sec, e_min;
    logic [5:0] e_hour;
    logic [9:0] e_day;
    logic [7:0] e_year;
    logic       e_lock;

    function automatic int wsum(input int lo, input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += rbits[lo + k] << k;
        return s;
    endfunction

    task automatic model_reset();
        mpos = -1; e_lock = 1'b0;
        e_sec = '0; e_min = '0; e_hour = '0; e_day = '0; e_year = '0;
    endtask

    task automatic model_step(input int t, output logic [4:0] es, output logic ee);
        int  i, u, te, h, v;
        bit  mk, ok;
        es = '0; ee = 1'b0;
        if (mpos == -1) begin
            if (t == 2) mpos = -2;
        end else if (mpos == -2) begin
            mpos = (t == 2) ? 0 : -1;
        end else begin
            i  = (mpos + 1) % 100;
            mk = (i == 0) || (i % 10 == 9);
            if (t == 3 || (mk && t != 2)) begin
                ee = 1'b1; e_lock = 1'b0; mpos = -1;
            end else if (!mk && t == 2) begin
                ee = 1'b1; e_lock = 1'b0; mpos = -2;
            end else begin
                mpos = i;
                ok   = 1'b1;
                if (!mk) rbits[i] = t;
                case (i)
                    9: begin
                        u = wsum(1, 4); te = wsum(6, 3);
                        ok = (u <= 9) && (te * 10 + u <= 59);
                        if (ok) begin e_sec = 7'(te * 16 + u); es[0] = 1'b1; end
                    end
                    19: begin
                        u = wsum(10, 4); te = wsum(15, 3);
                        ok = (u <= 9) && (te * 10 + u <= 59);
                        if (ok) begin e_min = 7'(te * 16 + u); es[1] = 1'b1; end
                    end
                    29: begin
                        u = wsum(20, 4); te = wsum(25, 2);
                        ok = (u <= 9) && (te * 10 + u <= 23);
                        if (ok) begin e_hour = 6'(te * 16 + u); es[2] = 1'b1; end
                    end
                    49: begin
                        u = wsum(30, 4); te = wsum(35, 4); h = wsum(40, 2);
                        v = h * 100 + te * 10 + u;
                        ok = (u <= 9) && (te <= 9) && (v >= 1) && (v <= 366);
                        if (ok) begin e_day = 10'(h * 256 + te * 16 + u); es[3] = 1'b1; end
                    end
                    59: begin
                        u = wsum(50, 4); te = wsum(55, 4);
                        ok = (u <= 9) && (te <= 9);
                        if (ok) begin e_year = 8'(te * 16 + u); es[4] = 1'b1; end
                    end
                    99: e_lock = 1'b1;
                    default: ;
                endcase
                if (!ok) begin ee = 1'b1; e_lock = 1'b0; mpos = -1; end
            end
        end
    endtask

    // Frame stimulus, index 0 = Pr.
    int fsym [100];

    task automatic put(input int lo, input int n, input int v);
        for (int k = 0; k < n; k++) fsym[lo + k] = (v >> k) & 1;
    endtask

    task automatic build_digits(input int su, st, mu, mt, hu, ht, du, dt, dh, yu, yt);
        for (int k = 0; k < 100; k++)
            fsym[k] = (k == 0 || k % 10 == 9) ? 2 : int'($urandom_range(0, 1));
        put(1, 4, su);  put(6, 3, st);
        put(10, 4, mu); put(15, 3, mt);
        put(20, 4, hu); put(25, 2, ht);
        put(30, 4, du); put(35, 4, dt); put(40, 2, dh);
        put(50, 4, yu); put(55, 4, yt);
    endtask

    task automatic build_time(input int s, m, hr, d, y);
        build_digits(s % 10, s / 10, m % 10, m / 10, hr % 10, hr / 10,
                     d % 10, (d / 10) % 10, d / 100, y % 10, y / 10);
    endtask

    task automatic build_random_time();
        build_time($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 23),
                   $urandom_range(1, 366), $urandom_range(0, 99));
    endtask

    task automatic send_sym(input int t, input int gap);
        logic [4:0] es;
        logic       ee;
        logic       busy;
        model_step(t, es, ee);
        Sym_vld = 1'b1; Sym_type = 2'(t);
        @(posedge Clk); #1;
        Sym_vld = 1'b0; Sym_type = 2'($urandom_range(0, 3));
        nsym++;
        check($sformatf("sym%0d_strobe", nsym), strobes, es);
        check($sformatf("sym%0d_ferr", nsym), Frame_err, ee);
        check($sformatf("sym%0d_locked", nsym), Locked, e_lock);
        check($sformatf("sym%0d_fields", nsym), fields, {e_sec, e_min, e_hour, e_day, e_year});
        busy = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge Clk); #1;
            busy |= (|strobes) | Frame_err;
        end
        if (gap > 0) check($sformatf("sym%0d_quiet", nsym), busy, 1'b0);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_sym(fsym[k], $urandom_range(0, 6));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fields"}, fields, 38'd0);
        check({tag, "_strobes"}, strobes, 5'd0);
        check({tag, "_locked"}, Locked, 1'b0);
        check({tag, "_ferr"}, Frame_err, 1'b0);
    endtask

    initial begin
        int  seen;
        logic tmo_strb;
        Rst_n = 1'b0; Sym_vld = 1'b0; Sym_type = 2'd0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset");
        Rst_n = 1'b1;

        // Acquisition from noise, then the reference frame.
        repeat ($urandom_range(5, 10)) send_sym($urandom_range(0, 1), $urandom_range(0, 4));
        send_sym(2, 2);
        build_time(27, 45, 13, 220, 20);
        send_range(0, 99);
        check("acq_sec", RxSecond, 7'h27);
        check("acq_min", RxMinute, 7'h45);
        check("acq_hour", RxHour, 6'h13);
        check("acq_day", RxDayOfYear, 10'h220);
        check("acq_year", RxYear, 8'h20);
        check("acq_locked", Locked, 1'b1);

        // Wrap into a second frame.
        build_time(28, 45, 13, 220, 20);
        send_range(0, 99);
        check("wrap_sec", RxSecond, 7'h28);
        check("wrap_locked", Locked, 1'b1);

        repeat (3) begin
            build_random_time();
            send_range(0, 99);
        end

        // Misplaced marker at index 14, then a new reference.
        build_random_time();
        fsym[14] = 2;
        send_range(0, 14);
        check("misp_locked", Locked, 1'b0);
        build_random_time();
        send_range(0, 99);
        check("misp_relock", Locked, 1'b1);

        // Invalid BCD in minutes units.
        build_random_time();
        put(10, 4, 12);
        send_range(0, 99);
        build_random_time();
        send_range(0, 99);
        check("bcd_relock", Locked, 1'b1);

        // Symbol stream stops after index 40.
        build_random_time();
        send_range(0, 39);
        send_sym(fsym[40], 0);
        seen = 0; tmo_strb = 1'b0;
        for (int k = 1; k <= TMO + 50 && seen == 0; k++) begin
            @(posedge Clk); #1;
            tmo_strb |= |strobes;
            if (Frame_err) seen = k;
        end
        check("tmo_latency", seen, TMO);
        check("tmo_locked", Locked, 1'b0);
        check("tmo_no_strobe", tmo_strb, 1'b0);
        mpos = -1; e_lock = 1'b0;

        send_sym(2, 3);
        build_random_time();
        send_range(0, 99);

        // Reset in the middle of a frame.
        build_random_time();
        send_range(0, 25);
        Rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        model_reset();
        repeat (8) send_sym($urandom_range(0, 1), $urandom_range(0, 3));
        send_sym(2, 1);
        build_random_time();
        send_range(0, 99);

        // Randomly corrupted frames; the model tracks loss and reacquisition.
        repeat (8) begin
            if ($urandom_range(0, 1) == 1) begin
                build_digits($urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 11),
                             $urandom_range(0, 7), $urandom_range(0, 11), $urandom_range(0, 3),
                             $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3),
                             $urandom_range(0, 11), $urandom_range(0, 11));
            end else begin
                build_random_time();
                fsym[$urandom_range(1, 99)] = $urandom_range(0, 3);
            end
            send_range(0, 99);
        end
        build_random_time();
        send_range(0, 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irig_b_frame_decoder.md
Name: irig_b_frame_decoder

Overview:
- Upstream neighbour of the IRIG-B BCD-to-seconds converter.
- Takes classified IRIG-B symbols (bit 0, bit 1, position marker) from the pulse-width demodulator and finds frame alignment from the double-marker reference (P0 followed by Pr).
- Assembles the BCD seconds, minutes, hours, day-of-year and year fields.
- Presents each field with a one-cycle valid strobe, in the order sec, min, hour, day, year, which is the order in which the converter consumes them.

Parameters:
- SYM_TIMEOUT, 1875000: max Clk cycles between Sym_vld pulses before alignment is dropped (1.5 symbol periods of 10 ms at 125 MHz).

Ports:
- Clk  in  1  125 MHz system clock.
- Rst_n  in  1  asynchronous reset, active low.
- Sym_vld  in  1  one-cycle pulse; Sym_type is valid.
- Sym_type  in  2  symbol class: 0 = bit 0, 1 = bit 1, 2 = position marker P, 3 = invalid.
- RxSecond  out  7  {tens[2:0], units[3:0]} BCD.
- RxMinute  out  7  {tens[2:0], units[3:0]} BCD.
- RxHour  out  6  {tens[1:0], units[3:0]} BCD.
- RxDayOfYear  out  10  {hundreds[1:0], tens[3:0], units[3:0]} BCD.
- RxYear  out  8  {tens[3:0], units[3:0]} BCD.
- Rx_sec_vld, Rx_min_vld, Rx_hour_vld, Rx_day_vld, Rx_year_vld  out  1 each  one-cycle field-valid strobes.
- Locked  out  1  high while frame alignment is held.
- Frame_err  out  1  one-cycle pulse on any alignment or format loss.

Behaviour:
- Reset:
  - All field outputs 0, all strobes 0, Locked 0, Frame_err 0.
  - State HUNT, symbol index 0, timeout counter 0.
- State machine, advancing only on Sym_vld:
  - HUNT: on P go to MARK1; on anything else stay.
  - MARK1: on P, this symbol is Pr; index <= 0 and go to FRAME. On any other symbol return to HUNT (no error pulse).
  - FRAME: index increments 0..99 and wraps 99 -> 0 on each symbol.
- Symbol checks in FRAME, applied to the symbol arriving at index i = previous index + 1 (wrapping):
  - Marker positions are i in {0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99}. Sym_type must be P there and must not be P elsewhere.
  - Sym_type 3 is always an error.
  - On an unexpected P: Frame_err pulse, Locked <= 0, go to MARK1, since that P may begin a new reference.
  - On any other error: Frame_err pulse, Locked <= 0, go to HUNT.
- Bit capture: data bits are LSB first into per-field shift registers.
  - Seconds units: indices 1-4. Seconds tens: 6-8.
  - Minutes units: 10-13. Minutes tens: 15-17.
  - Hours units: 20-23. Hours tens: 25-26.
  - Day units: 30-33. Day tens: 35-38. Day hundreds: 40-41.
  - Year units: 50-53. Year tens: 55-58.
  - All other non-marker indices are don't-care and are not checked.
- Field publish: on acceptance of the marker at the index below, the assembled field is checked, then the output register is loaded and its strobe asserted in the next cycle (latency 1 Clk from Sym_vld).
  - Index 9: seconds.
  - Index 19: minutes.
  - Index 29: hours.
  - Index 49: day.
  - Index 59: year.
- Field check before publish:
  - Any units or tens digit > 9 is an error.
  - Seconds > 59, minutes > 59, hours > 23, day of year 0 or > 366 are errors.
  - On a failed check: no strobe, output register keeps its old value, Frame_err pulse, Locked <= 0, go to HUNT.
  - Fields already published in that frame stand.
- Field outputs hold their value between strobes. At most one strobe is active in any cycle.
- Locked:
  - Set 1 on acceptance of the index-99 marker of an error-free frame.
  - Cleared by any error or timeout.
  - Strobes are issued whether or not Locked is high, so the first frame after acquisition is used.
- Timeout:
  - The counter resets on every Sym_vld and otherwise increments, saturating.
  - In MARK1 or FRAME, reaching SYM_TIMEOUT gives a Frame_err pulse, Locked <= 0 and a return to HUNT.
  - In HUNT the counter runs but has no effect.
- Sym_vld during the strobe cycle is processed normally; there are no back-to-back hazards because publish uses registered fields.
- Rst_n asserted mid-frame: immediate return to reset values; no partial strobe is emitted.

Test Plan:
- Acquisition and decode: random bits, then P,P, then a frame encoding year 20, day 220, 13:45:27 -> RxSecond=7'h27, RxMinute=7'h45, RxHour=6'h13, RxDayOfYear=10'h220, RxYear=8'h20. The strobes each fire once, 1 cycle after the symbols at indices 9, 19, 29, 49, 59, in that order. Locked=1 after index 99.
- Wrap: two consecutive frames with seconds 27 then 28 -> second frame publishes RxSecond=7'h28 with no Frame_err and Locked remaining 1.
- Misplaced marker: P at index 14 while locked -> Frame_err pulse, Locked=0, no Rx_min_vld for that frame. A following P restarts alignment from MARK1.
- Invalid BCD: minutes units bits = 4'hC -> Rx_min_vld suppressed, RxMinute unchanged, Frame_err pulse, state HUNT. Rx_sec_vld of the same frame was already issued.
- Timeout: SYM_TIMEOUT overridden to 100; stop Sym_vld at index 40 -> Frame_err exactly 100 cycles after the last Sym_vld, Locked=0, no Rx_day_vld.
- Reset mid-frame: assert Rst_n=0 at index 25 -> all outputs 0 immediately. After release, no strobes until a new P,P reference is seen.
